series_job_sequencer: RTL

Controller that sequences the series-evaluation datapath (8-bit signed sample in, order `n`, 8-bit signed result out, valid/ready/overflow/error) through a programmed list of jobs. Each job is one order value applied to a full stream of samples from an external sample memory. The block issues the datapath start, streams samples under the datapath's `ready`, waits out the pipeline drain, forwards results tagged with the job index, and counts overflows and results. It sits between the system host (job table, go/done) and the datapath instance.

---
 rtl/series_job_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/series_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : series_job_sequencer
// Brief    : Walks a programmed job table, driving the series-evaluation
//            datapath with sample streams and collecting tagged results.
// Revision : 1.0 - initial release
// ============================================================================
module series_job_sequencer #(
    parameter int NUM_SAMPLES = 20,
    parameter int MAX_JOBS    = 8,
    parameter int DRAIN_SHORT = 3,
    parameter int DRAIN_LONG  = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(MAX_JOBS)-1:0] cfg_addr,
    input  logic [2:0]                  cfg_order,
    input  logic                        go,
    output logic [4:0]                  smp_addr,
    input  logic [7:0]                  smp_data,
    output logic                        dp_start,
    output logic [2:0]                  dp_n,
    output logic [7:0]                  dp_x,
    output logic                        dp_x_valid,
    input  logic                        dp_ready,
    input  logic                        dp_valid,
    input  logic                        dp_overflow,
    input  logic                        dp_error,
    input  logic [7:0]                  dp_y,
    output logic                        res_valid,
    output logic [7:0]                  res_y,
    output logic                        res_ovf,
    output logic [$clog2(MAX_JOBS)-1:0] res_job,
    output logic [15:0]                 res_cnt,
    output logic [15:0]                 ovf_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int c_JW = $clog2(MAX_JOBS);
    localparam int c_DW = $clog2(DRAIN_LONG + 1);

    localparam logic [c_JW-1:0] c_JOB_ONE   = 1;
    localparam logic [c_JW-1:0] c_LAST_JOB  = c_JW'(MAX_JOBS - 1);
    localparam logic [4:0]      c_IDX_ONE   = 5'd1;
    localparam logic [4:0]      c_LAST_IDX  = 5'(NUM_SAMPLES - 1);
    localparam logic [c_DW-1:0] c_DRAIN_S   = c_DW'(DRAIN_SHORT);
    localparam logic [c_DW-1:0] c_DRAIN_L   = c_DW'(DRAIN_LONG);
    localparam logic [c_DW-1:0] c_DRAIN_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SETUP = 3'd2,
        S_FEED  = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_table [MAX_JOBS];
    logic [c_JW-1:0] r_job;
    logic [2:0]      r_dp_n;
    logic [4:0]      r_idx;
    logic [c_DW-1:0] r_drain;
    logic            r_res_valid;
    logic [7:0]      r_res_y;
    logic            r_res_ovf;
    logic [c_JW-1:0] r_res_job;
    logic [15:0]     r_res_cnt;
    logic [15:0]     r_ovf_cnt;
    logic            r_err;

    logic            w_dp_start;
    logic            w_x_valid;
    logic            w_done;
    logic            w_go_ok;
    logic            w_load_n;
    logic [2:0]      w_n_val;
    logic            w_job_inc;
    logic            w_idx_clr;
    logic            w_idx_inc;
    logic            w_drain_load;
    logic            w_set_err;
    logic            w_capture;
    logic [2:0]      w_entry0;
    logic [2:0]      w_next_order;

    // A write issued together with go must already be visible to the list walk.
    assign w_entry0     = (cfg_we && (cfg_addr == '0)) ? cfg_order : r_table[0];
    assign w_next_order = r_table[r_job + c_JOB_ONE];
    assign w_capture    = dp_valid && (r_state != S_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_dp_start   = 1'b0;
        w_x_valid    = 1'b0;
        w_done       = 1'b0;
        w_go_ok      = 1'b0;
        w_load_n     = 1'b0;
        w_n_val      = r_dp_n;
        w_job_inc    = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_drain_load = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_go_ok     = 1'b1;
                    w_load_n    = 1'b1;
                    w_n_val     = w_entry0;
                    w_state_nxt = (w_entry0 == 3'd0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                if (dp_error || (r_dp_n == 3'd1)) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_dp_start  = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (dp_error) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_idx_clr   = 1'b1;
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                if (dp_error) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (dp_ready) begin
                    w_x_valid = 1'b1;
                    w_idx_inc = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_drain_load = 1'b1;
                        w_state_nxt  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (dp_error) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (r_drain <= c_DRAIN_ONE) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if ((r_job == c_LAST_JOB) || (w_next_order == 3'd0)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_job_inc   = 1'b1;
                    w_load_n    = 1'b1;
                    w_n_val     = w_next_order;
                    w_state_nxt = S_START;
                end
            end
            S_DONE, S_ERR: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < MAX_JOBS; i++) r_table[i] <= '0;
            r_job       <= '0;
            r_dp_n      <= '0;
            r_idx       <= '0;
            r_drain     <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_ovf   <= 1'b0;
            r_res_job   <= '0;
            r_res_cnt   <= '0;
            r_ovf_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (cfg_we && (r_state == S_IDLE)) r_table[cfg_addr] <= cfg_order;
            if (w_go_ok)        r_job <= '0;
            else if (w_job_inc) r_job <= r_job + c_JOB_ONE;
            if (w_load_n) r_dp_n <= w_n_val;
            if (w_idx_clr)      r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + c_IDX_ONE;
            // Drain length follows the pipeline depth implied by the job order.
            if (w_drain_load)              r_drain <= (r_dp_n <= 3'd4) ? c_DRAIN_S : c_DRAIN_L;
            else if (r_state == S_DRAIN)   r_drain <= r_drain - c_DRAIN_ONE;
            if (w_go_ok)        r_err <= 1'b0;
            else if (w_set_err) r_err <= 1'b1;
            r_res_valid <= w_capture;
            if (w_capture) begin
                r_res_y   <= dp_y;
                r_res_ovf <= dp_overflow;
                r_res_job <= r_job;
            end
            if (w_go_ok) begin
                r_res_cnt <= '0;
                r_ovf_cnt <= '0;
            end else if (w_capture) begin
                r_res_cnt <= r_res_cnt + 16'd1;
                if (dp_overflow && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign smp_addr   = r_idx;
    assign dp_start   = w_dp_start;
    assign dp_n       = r_dp_n;
    assign dp_x       = (r_state == S_FEED) ? smp_data : 8'd0;
    assign dp_x_valid = w_x_valid;
    assign res_valid  = r_res_valid;
    assign res_y      = r_res_y;
    assign res_ovf    = r_res_ovf;
    assign res_job    = r_res_job;
    assign res_cnt    = r_res_cnt;
    assign ovf_cnt    = r_ovf_cnt;
    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign err        = r_err;

endmodule
`default_nettype wire
